// File: rtl/serial_divisibility_by_n.sv
// Serial remainder tracker: running value mod DIVISOR of a bit stream, MSB- or LSB-first,
// with a divisibility flag and a saturating bit count. in_first restarts the number in-band.
module serial_divisibility_by_n #(
    parameter int DIVISOR   = 5,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16,
    localparam int REM_W    = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             new_bit,
    output logic [REM_W-1:0] rem,
    output logic             div_by_n,
    output logic [CNT_W-1:0] bit_count
);

    if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
        $error("serial_divisibility_by_n: DIVISOR must be in 2..255");
    end

    localparam logic [REM_W:0] N_EXT = (REM_W+1)'(DIVISOR);

    logic [REM_W-1:0] w;
    logic [REM_W-1:0] base_r, base_w, w_eff;
    logic [CNT_W-1:0] base_c;
    logic             r_ok, w_ok;
    logic [REM_W:0]   sum, sum_red, w_dbl, w_red;
    logic [REM_W-1:0] rem_d, w_d;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        rem_d   = rem;
        w_d     = w;
        cnt_d   = bit_count;
        base_r  = in_first ? '0 : rem;
        base_w  = in_first ? REM_W'(1) : w;
        base_c  = in_first ? '0 : bit_count;
        r_ok    = {1'b0, base_r} < N_EXT;
        w_ok    = {1'b0, base_w} < N_EXT;
        w_eff   = w_ok ? base_w : REM_W'(1);
        // Both sums stay below 2N, so one conditional subtract replaces a modulo.
        if (MSB_FIRST)
            sum = {base_r, new_bit};
        else
            sum = {1'b0, base_r} + (new_bit ? {1'b0, w_eff} : '0);
        sum_red = (sum >= N_EXT) ? sum - N_EXT : sum;
        w_dbl   = {w_eff, 1'b0};
        w_red   = (w_dbl >= N_EXT) ? w_dbl - N_EXT : w_dbl;
        if (in_valid) begin
            rem_d = r_ok ? sum_red[REM_W-1:0] : '0;
            w_d   = w_red[REM_W-1:0];
            cnt_d = (&base_c) ? base_c : base_c + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem       <= '0;
            w         <= REM_W'(1);
            bit_count <= '0;
        end else begin
            rem       <= rem_d;
            w         <= w_d;
            bit_count <= cnt_d;
        end
    end

    assign div_by_n = (rem == '0);

endmodule

// File: tb/tb_serial_divisibility_by_n.sv
// Bench: several divisor/order configurations share one input stream; each is checked every
// cycle against an integer-value model, plus directed literal expectations.
module tb_serial_divisibility_by_n;

    localparam int NCFG = 14;
    localparam int CFG_N   [NCFG] = '{5, 3, 7, 2, 3, 5, 6, 6, 8, 8, 13, 13, 255, 255};
    localparam bit CFG_MSB [NCFG] = '{1, 0, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    localparam int CFG_CW  [NCFG] = '{16, 16, 16, 4, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_first = 1'b0;
    logic new_bit = 1'b0;

    logic [7:0]  rem_a [NCFG];
    logic        div_a [NCFG];
    logic [15:0] cnt_a [NCFG];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int RW = (CFG_N[g] > 2) ? $clog2(CFG_N[g]) : 1;
        logic [RW-1:0]        r;
        logic                 d;
        logic [CFG_CW[g]-1:0] c;
        serial_divisibility_by_n #(
            .DIVISOR(CFG_N[g]), .MSB_FIRST(CFG_MSB[g]), .CNT_W(CFG_CW[g])
        ) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
            .new_bit(new_bit), .rem(r), .div_by_n(d), .bit_count(c)
        );
        assign rem_a[g] = 8'(r);
        assign div_a[g] = d;
        assign cnt_a[g] = 16'(c);
    end

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;
    int stream_len = 0;

    // Model: whole integer value of the current number, remainder by plain %.
    logic [63:0] val [NCFG];
    int          nb  [NCFG];
    longint      cnt [NCFG];

    always @(posedge clk) begin
        for (int i = 0; i < NCFG; i++) begin
            if (rst) begin
                val[i] = '0; nb[i] = 0; cnt[i] = 0;
            end else if (in_valid) begin
                if (in_first) begin
                    val[i] = '0; nb[i] = 0; cnt[i] = 0;
                end
                if (CFG_MSB[i]) val[i] = (val[i] << 1) | 64'(new_bit);
                else            val[i] = val[i] | (64'(new_bit) << nb[i]);
                nb[i]++;
                if (cnt[i] < (longint'(1) << CFG_CW[i]) - 1) cnt[i]++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NCFG; i++) begin
                longint er;
                er = longint'(val[i] % 64'(CFG_N[i]));
                vectors += 3;
                if (longint'(rem_a[i]) != er) begin
                    miscompares++;
                    $display("FAIL model_rem cfg%0d t=%0t: got %0d want %0d", i, $time, rem_a[i], er);
                end
                if (div_a[i] != (er == 0)) begin
                    miscompares++;
                    $display("FAIL model_div cfg%0d t=%0t: got %0d want %0d", i, $time, div_a[i], er == 0);
                end
                if (longint'(cnt_a[i]) != cnt[i]) begin
                    miscompares++;
                    $display("FAIL model_cnt cfg%0d t=%0t: got %0d want %0d", i, $time, cnt_a[i], cnt[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic send(input bit f, input bit b);
        in_valid = 1'b1; in_first = f; new_bit = b;
        stream_len = f ? 1 : stream_len + 1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_rst(input bit v);
        rst = 1'b1; in_valid = v; in_first = 1'b0; new_bit = 1'b1;
        stream_len = 0;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_on = 1'b1;
        chk("reset_rem", rem_a[0], 0);
        chk("reset_div", div_a[0], 1);
        chk("reset_cnt", cnt_a[0], 0);

        // N=5 MSB-first: 1,0,1,0 (value 10)
        send(1, 1); chk("n5_rem1", rem_a[0], 1); chk("n5_div1", div_a[0], 0);
        send(0, 0); chk("n5_rem2", rem_a[0], 2);
        send(0, 1); chk("n5_rem3", rem_a[0], 0); chk("n5_div3", div_a[0], 1);
        send(0, 0); chk("n5_rem4", rem_a[0], 0); chk("n5_cnt4", cnt_a[0], 4);
        chk("n2_rem_last", rem_a[3], 0);

        // N=3 LSB-first: 0,1,1 (value 6), then 1 (value 14)
        send(1, 0); chk("n3l_rem1", rem_a[1], 0); chk("n3l_div1", div_a[1], 1);
        send(0, 1); chk("n3l_rem2", rem_a[1], 2); chk("n3l_div2", div_a[1], 0);
        send(0, 1); chk("n3l_rem3", rem_a[1], 0);
        send(0, 1); chk("n3l_rem4", rem_a[1], 2);

        // N=7 MSB-first with gaps: 1,1,1 -> 0
        send(1, 1); idle(3);
        chk("n7_hold_rem", rem_a[2], 1); chk("n7_hold_cnt", cnt_a[2], 1);
        send(0, 1); idle(3);
        chk("n7_hold_rem2", rem_a[2], 3);
        send(0, 1);
        chk("n7_rem", rem_a[2], 0); chk("n7_div", div_a[2], 1);

        // in_first mid-stream discards history, then reset mid-number
        send(1, 1); send(0, 1); chk("restart_pre", rem_a[0], 3);
        send(1, 1); chk("restart_rem", rem_a[0], 1); chk("restart_cnt", cnt_a[0], 1);
        do_rst(0);
        chk("rst_rem", rem_a[0], 0); chk("rst_div", div_a[0], 1); chk("rst_cnt", cnt_a[0], 0);
        send(0, 1); chk("post_rst_rem", rem_a[0], 1); chk("post_rst_cnt", cnt_a[0], 1);
        do_rst(1);
        chk("rst_prio_cnt", cnt_a[0], 0); chk("rst_prio_rem", rem_a[0], 0);

        // CNT_W=4, N=2: 20 bits ending in 0
        for (int j = 0; j < 20; j++) begin
            bit b;
            b = (j == 19) ? 1'b0 : (j % 3 == 0);
            send(j == 0, b);
            chk("n2_rem_eq_bit", rem_a[3], int'(b));
        end
        chk("n2_sat_cnt", cnt_a[3], 15); chk("n2_sat_div", div_a[3], 1);

        // consecutive in_first: 1-bit numbers
        send(1, 1); chk("one_bit_rem", rem_a[0], 1); chk("one_bit_cnt", cnt_a[0], 1);
        send(1, 0); chk("one_bit_rem0", rem_a[0], 0); chk("one_bit_cnt0", cnt_a[0], 1);
        send(1, 1); chk("one_bit_n255", rem_a[12], 1); chk("one_bit_n255l", rem_a[13], 1);

        // 13 LSB-first: 1,0,1,1 = 13 -> 0 ; 13 MSB-first: 1,0,1,1 = 11
        send(1, 1); send(0, 0); send(0, 1); send(0, 1);
        chk("n13_lsb", rem_a[11], 0); chk("n13_msb", rem_a[10], 11);

        // random cross-check
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_rst($urandom_range(0, 1) == 1);
            end else if ($urandom_range(0, 9) < 7) begin
                bit f;
                f = ($urandom_range(0, 19) == 0) || (stream_len >= 60);
                send(f, 1'($urandom_range(0, 1)));
            end else begin
                idle(1);
            end
        end

        idle(2);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_divisibility_by_n.md
# serial_divisibility_by_n

Serial remainder tracker for a binary number arriving one bit per accepted cycle, generalised to any compile-time divisor and either bit order. Reports the running remainder, a divisibility flag and a bit count. An `in_first` marker lets back-to-back numbers share the stream without a reset. It is the parametrised successor of the team's fixed divide-by-3/5 serial checkers and sits in the same serial-arithmetic exercise set.

## Interface
- `DIVISOR`, default 5: divisor N, legal range 2..255; elaboration error outside the range.
- `MSB_FIRST`, default 1: 1 = bits arrive MSB first; 0 = bits arrive LSB first.
- `CNT_W`, default 16: width of `bit_count`.
- Derived localparam `REM_W` = max(1, $clog2(DIVISOR)).

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `new_bit` is presented and is accepted this cycle.
- `in_first`  in  1  qualified by `in_valid`; the accepted bit is the first bit of a new number.
- `new_bit`  in  1  data bit.
- `rem`  out  REM_W  registered remainder of the number accepted so far, mod N.
- `div_by_n`  out  1  `rem == 0`; decoded from the state register, no extra latency.
- `bit_count`  out  CNT_W  bits accepted in the current number; saturates at 2^CNT_W-1.

## Operation
- State registers: `rem` r, `bit_count`. LSB-first mode adds a weight register w = 2^k mod N, where k is the index of the next bit.
- Reset values: r=0, w=1, `bit_count`=0, so `div_by_n`=1. An empty number counts as 0, which is divisible.
- Accept = `in_valid`. With `in_valid`=0, all state holds and `in_first` and `new_bit` are ignored.
- Base on accept: if `in_first`=1, the update uses base r=0, w=1, count=0; otherwise it uses the current registers.
- MSB-first update: r' = (2r + b) mod N.
- LSB-first update: r' = (r + b·w) mod N, then w' = (2w) mod N.
- `bit_count`' = base count + 1, saturating. Saturation does not affect the remainder.
- Arithmetic: 2r+b and r+w are both < 2N. Compute each in REM_W+1 bits and reduce with one conditional subtract of N. No divider or `%` operator in the datapath.
- Implementation is an FSM over N remainder states: a state register plus next-state logic, with a default assignment to the hold value.
- Unreachable encodings (r ≥ N when N is not a power of two) must return to r=0 on the next accept, or be cleared by reset. They never occur in legal operation.

## Timing
- Latency 1: a bit accepted at edge t is reflected in `rem`, `div_by_n` and `bit_count` after edge t.
- Full throughput: one bit per cycle, with no stall and no ready signal.
- `rst` has priority over an accept in the same cycle; that bit is lost.
- Reset mid-number discards all history. The next bit is treated as the first bit even if `in_first`=0.
- `in_first`=1 on consecutive accepts gives a series of 1-bit numbers: `rem` = b mod N and `bit_count`=1 each time.

## Test plan
- N=5, MSB-first, bits 1,0,1,0 (value 10) on consecutive cycles -> `rem` 1,2,0,0; `div_by_n` 0,0,1,1; `bit_count` 1..4.
- N=3, LSB-first, bits 0,1,1 (value 6) -> `rem` 0,2,0; `div_by_n` 1,0,1. Then bit 1 (value 14) -> `rem` 2.
- N=7, MSB-first, bits 1,1,1 with `in_valid` dropped for 3 cycles between each bit -> outputs hold during gaps; final `rem`=0 and `div_by_n`=1.
- N=5, MSB-first, stream 1,1 then accept bit 1 with `in_first`=1 -> `rem`=1 and `bit_count`=1 (old value 3 discarded). Then `rst` mid-number -> `rem`=0, `div_by_n`=1, `bit_count`=0 next cycle.
- CNT_W=4, N=2, 20 accepted bits ending in 0 -> `bit_count` sticks at 15, `rem`=0, `div_by_n`=1; `rem` always equals the last bit.
- Randomised cross-check for N in {3,5,6,8,13,255}, both modes: per-cycle compare against a reference model that reconstructs the full integer for up to 64 bits, including random `in_valid` gaps and `in_first` pulses.
